// File: rtl/bomb_placement_controller_if.sv
// Board-generation request/result bundle between the switch encoder / game
// logic side (master) and the bomb placement controller (slave).
//   start        : single-cycle request to build a new board
//   bomb_count   : requested number of bombs, latched on an accepted start
//   busy         : generation in progress
//   done         : one-cycle pulse when a board is finished or rejected
//   err          : last request asked for zero bombs (sticky until next start)
//   bomb_map     : one bit per cell, bit i = row i/8, col i%8
//   placed_count : bombs placed so far in the current or last board
interface bomb_placement_controller_if #(
    parameter int unsigned CELLS = 64
);
    localparam int unsigned ADDR_W = $clog2(CELLS);

    logic              start;
    logic [ADDR_W-1:0] bomb_count;
    logic              busy;
    logic              done;
    logic              err;
    logic [CELLS-1:0]  bomb_map;
    logic [ADDR_W-1:0] placed_count;

    modport master (
        output start,
        output bomb_count,
        input  busy,
        input  done,
        input  err,
        input  bomb_map,
        input  placed_count
    );

    modport slave (
        input  start,
        input  bomb_count,
        output busy,
        output done,
        output err,
        output bomb_map,
        output placed_count
    );
endinterface

// File: rtl/bomb_placement_controller.sv
// Minesweeper board generator. On an accepted start it latches the bomb
// count, clears the map and then drops bombs on distinct cells chosen by a
// free-running LFSR, one attempt per cycle, until the count is reached.
// The finished map is held until the next start.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : request/result bundle (slave side), see the interface file
module bomb_placement_controller #(
    parameter int unsigned          CELLS  = 64,
    parameter int unsigned          LFSR_W = 16,
    parameter logic [LFSR_W-1:0]    SEED   = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    bomb_placement_controller_if.slave   bus
);
    localparam int unsigned ADDR_W = $clog2(CELLS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        PLACE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] placed_q, placed_d;
    logic [CELLS-1:0]  map_q, map_d;
    logic              err_q, err_d;
    logic [LFSR_W-1:0] lfsr_q;
    logic              lfsr_fb;
    logic [ADDR_W-1:0] cand;
    logic [ADDR_W-1:0] placed_inc;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, right-shifting, feedback into the MSB
    assign lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign cand       = lfsr_q[ADDR_W-1:0];
    assign placed_inc = placed_q + ADDR_W'(1);

    // State and datapath registers; the LFSR advances in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            placed_q <= '0;
            map_q    <= '0;
            err_q    <= 1'b0;
            lfsr_q   <= SEED;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            placed_q <= placed_d;
            map_q    <= map_d;
            err_q    <= err_d;
            lfsr_q   <= {lfsr_fb, lfsr_q[LFSR_W-1:1]};
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        placed_d = placed_q;
        map_d    = map_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    target_d = bus.bomb_count;
                    err_d    = 1'b0;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                map_d    = '0;
                placed_d = '0;
                if (target_q == '0) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = PLACE;
                end
            end
            PLACE: begin
                // Occupied candidate: just wait for the next LFSR value
                if (!map_q[cand]) begin
                    map_d[cand] = 1'b1;
                    placed_d    = placed_inc;
                    if (placed_inc == target_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status decodes straight from the state register
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.err          = err_q;
    assign bus.bomb_map     = map_q;
    assign bus.placed_count = placed_q;

endmodule
